// File: rtl/gnrl_sync_pkg.sv
// Shared definitions for the pulse-synchronizer helper blocks.
package gnrl_sync_pkg;

    localparam int unsigned GAP_MIN = 1;

    typedef enum logic {
        PACE_IDLE = 1'b0,
        PACE_GAP  = 1'b1
    } pace_state_e;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter; flags an increment lost at the maximum value.
module sat_updown_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_drop_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max_s;
    logic         at_zero_s;

    assign at_max_s  = (cnt_q == {W{1'b1}});
    assign at_zero_s = (cnt_q == {W{1'b0}});
    assign cnt_o     = cnt_q;

    // next count; simultaneous inc and dec cancel even at the maximum
    always_comb begin
        cnt_d      = cnt_q;
        sat_drop_o = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (at_max_s) begin
                    sat_drop_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            2'b01: begin
                if (at_zero_s) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sync_pulse_pacer.sv
// Paces event strobes into single-cycle pulses at least GAP idle cycles apart,
// so a downstream toggle synchronizer never merges two events.
module sync_pulse_pacer
    import gnrl_sync_pkg::*;
#(
    parameter int unsigned GAP  = 4,
    parameter int unsigned CNTW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            evt_in,
    input  logic            ovf_clr,
    output logic            pulse_out,
    output logic [CNTW-1:0] pending,
    output logic            overflow,
    output logic            busy
);

    localparam int unsigned GW = $clog2(GAP + 1);

    if (GAP < GAP_MIN) begin : g_gap_check
        $error("sync_pulse_pacer: GAP must be at least GAP_MIN");
    end

    pace_state_e state_q, state_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          pulse_q, pulse_d;
    logic          ovf_q, ovf_d;
    logic          tail_q, tail_d;
    logic          emit_s;
    logic          drop_s;

    sat_updown_cnt #(.W(CNTW)) u_pend_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (evt_in),
        .dec_i     (emit_s),
        .cnt_o     (pending),
        .sat_drop_o(drop_s)
    );

    assign emit_s = (state_q == PACE_IDLE) && ((pending != {CNTW{1'b0}}) || evt_in);

    // gap sequencing; tail_q marks the first IDLE cycle after a gap, which still counts as busy
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        pulse_d = 1'b0;
        tail_d  = 1'b0;
        case (state_q)
            PACE_IDLE: begin
                if (emit_s) begin
                    pulse_d = 1'b1;
                    gcnt_d  = GW'(GAP);
                    state_d = PACE_GAP;
                end else begin
                    gcnt_d  = {GW{1'b0}};
                    state_d = PACE_IDLE;
                end
            end
            PACE_GAP: begin
                gcnt_d = gcnt_q - GW'(1);
                if (gcnt_q == GW'(1)) begin
                    state_d = PACE_IDLE;
                    tail_d  = 1'b1;
                end else begin
                    state_d = PACE_GAP;
                end
            end
            default: begin
                state_d = PACE_IDLE;
                gcnt_d  = {GW{1'b0}};
            end
        endcase
    end

    // sticky overflow: a drop in the same cycle as a clear wins
    always_comb begin
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PACE_IDLE;
            gcnt_q  <= {GW{1'b0}};
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
            tail_q  <= tail_d;
        end
    end

    assign pulse_out = pulse_q;
    assign overflow  = ovf_q;
    assign busy      = (pending != {CNTW{1'b0}}) || (state_q == PACE_GAP) || tail_q;

endmodule

// File: tb/tb_sync_pulse_pacer.sv
// Self-checking bench for sync_pulse_pacer: pulse-schedule scoreboard, a vector
// table for a single event, and a GAP=1 instance for the tightest pacing.
module tb_sync_pulse_pacer;

    localparam int GAP  = 4;
    localparam int MAXP = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       evt_in;
    logic       ovf_clr;
    logic       pulse_out;
    logic [3:0] pending;
    logic       overflow;
    logic       busy;

    logic       evt1;
    logic       clr1;
    logic       pulse1;
    logic [3:0] pending1;
    logic       ovf1;
    logic       busy1;

    always #5 clk = ~clk;

    sync_pulse_pacer #(.GAP(GAP), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .evt_in(evt_in), .ovf_clr(ovf_clr),
        .pulse_out(pulse_out), .pending(pending), .overflow(overflow), .busy(busy)
    );

    sync_pulse_pacer #(.GAP(1), .CNTW(4)) dut_g1 (
        .clk(clk), .reset(reset), .evt_in(evt1), .ovf_clr(clr1),
        .pulse_out(pulse1), .pending(pending1), .overflow(ovf1), .busy(busy1)
    );

    typedef struct packed {
        logic       evt;
        logic       e_pulse;
        logic       e_busy;
        logic [3:0] e_pend;
    } vec_t;

    vec_t tab[9];

    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    int   last_p = -1000;
    int   sched[$];
    logic m_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, t, act, exp);
        end
    endtask

    function automatic int m_pend(input int tt);
        int n = 0;
        foreach (sched[i]) if (sched[i] > tt) n++;
        return n;
    endfunction

    // One cycle, entered and left at a negedge: check outputs, drive inputs, update model.
    task automatic cyc(input logic e, input logic c, input logic r);
        int   pend;
        int   cand;
        logic exp_pulse;
        logic emit_old;
        logic drop;
        exp_pulse = (sched.size() > 0) && (sched[0] == t);
        pend      = m_pend(t);
        chk("pulse_out", int'(pulse_out), int'(exp_pulse));
        chk("pending", int'(pending), pend);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("busy", int'(busy), int'((pend != 0) || (t <= last_p + GAP)));
        if (exp_pulse) void'(sched.pop_front());
        evt_in  = e;
        ovf_clr = c;
        reset   = r;
        drop    = 1'b0;
        if (r) begin
            sched.delete();
            last_p = -1000;
            m_ovf  = 1'b0;
        end else begin
            if (e) begin
                cand     = (t + 1 > last_p + GAP + 1) ? t + 1 : last_p + GAP + 1;
                emit_old = (sched.size() > 0) && (sched[0] == t + 1);
                if (cand != t + 1 && !emit_old && pend == MAXP) begin
                    drop = 1'b1;
                end else begin
                    sched.push_back(cand);
                    last_p = cand;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        @(negedge clk);
        t++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d actual=running required=finished", t);
        $fatal(1, "timeout");
    end

    initial begin
        // single event at row 1: pulse one cycle later, busy for GAP+1 cycles
        tab[0] = '{1'b0, 1'b0, 1'b0, 4'd0};
        tab[1] = '{1'b1, 1'b0, 1'b0, 4'd0};
        tab[2] = '{1'b0, 1'b1, 1'b1, 4'd0};
        tab[3] = '{1'b0, 1'b0, 1'b1, 4'd0};
        tab[4] = '{1'b0, 1'b0, 1'b1, 4'd0};
        tab[5] = '{1'b0, 1'b0, 1'b1, 4'd0};
        tab[6] = '{1'b0, 1'b0, 1'b1, 4'd0};
        tab[7] = '{1'b0, 1'b0, 1'b0, 4'd0};
        tab[8] = '{1'b0, 1'b0, 1'b0, 4'd0};

        reset   = 1'b1;
        evt_in  = 1'b0;
        ovf_clr = 1'b0;
        evt1    = 1'b0;
        clr1    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // GAP=1 instance with evt held: pulses on odd cycles, backlog +1 every 2 cycles
        for (int k = 0; k < 12; k++) begin
            chk("g1_pulse", int'(pulse1), k % 2);
            chk("g1_pending", int'(pending1), k / 2);
            evt1 = 1'b1;
            @(negedge clk);
        end
        chk("g1_busy", int'(busy1), 1);
        evt1 = 1'b0;

        for (int i = 0; i < 9; i++) begin
            chk("tab_pulse", int'(pulse_out), int'(tab[i].e_pulse));
            chk("tab_busy", int'(busy), int'(tab[i].e_busy));
            chk("tab_pending", int'(pending), int'(tab[i].e_pend));
            cyc(tab[i].evt, 1'b0, 1'b0);
        end

        // burst of three
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (30) cyc(1'b0, 1'b0, 1'b0);

        // overflow: 20 back-to-back events from idle
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        repeat (100) cyc(1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", int'(overflow), 1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // clear coincides with the drop: set wins
        repeat (19) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovf_race", int'(overflow), 1);
        repeat (100) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // reset with backlog of 5 while in a gap
        repeat (7) cyc(1'b1, 1'b0, 1'b0);
        chk("pre_reset_pending", int'(pending), 5);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (25) cyc(1'b0, 1'b0, 1'b0);

        chk("sb_empty", sched.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
